serial_subtractor: RTL

- Bit-serial, LSB-first subtractor computing diff = a - b over WIDTH clock cycles.
- One gate-level full-subtractor cell plus a borrow flip-flop.
- Sequential counterpart to the combinational full adder in the ADDER_SUB group.
- Used where area matters more than latency; start/done handshake with the requester.

---
 rtl/serial_subtractor_pkg.sv | 11 +
 rtl/serial_subtractor_full_subtractor.sv | 34 +++
 rtl/serial_subtractor.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Purpose : Shared type definitions for the bit-serial subtractor slice.
// Contents: state_t - 2-bit FSM state type. The encodings themselves are
//           localparams inside serial_subtractor.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

   typedef logic [1:0] state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Purpose : Gate-level one-bit full subtractor cell (x - y - bin).
// Ports   : a    - minuend bit
//           b    - subtrahend bit
//           bin  - borrow in
//           diff - difference bit  = a ^ b ^ bin
//           bout - borrow out      = (~a & b) | (~(a ^ b) & bin)
// -----------------------------------------------------------------------------
module full_subtractor (
   input  wire a,
   input  wire b,
   input  wire bin,
   output wire diff,
   output wire bout
);

   wire w_axb;
   wire w_na;
   wire w_nxab;
   wire w_t1;
   wire w_t2;

   xor g_x1 (w_axb, a, b);
   xor g_x2 (diff, w_axb, bin);

   // Borrow is generated when a=0,b=1, or propagated when a==b and bin=1.
   not g_n1 (w_na, a);
   and g_a1 (w_t1, w_na, b);
   not g_n2 (w_nxab, w_axb);
   and g_a2 (w_t2, w_nxab, bin);
   or  g_o1 (bout, w_t1, w_t2);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Purpose : Bit-serial, LSB-first subtractor computing diff = a - b over WIDTH
//           clock cycles with one full-subtractor cell and a borrow flop.
// Ports   : clk        - rising-edge clock
//           rst_n      - synchronous active-low reset
//           start      - request, sampled only while ready=1
//           a, b       - minuend / subtrahend, captured on an accepted start
//           ready      - block can accept start (IDLE or DONE)
//           busy       - subtraction in progress (RUN)
//           done       - one-cycle pulse, diff/borrow_out valid
//           diff       - a - b modulo 2^WIDTH (held until next done or reset)
//           borrow_out - final borrow, 1 when a < b unsigned
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_sa;
   logic [WIDTH-1:0]   r_sb;
   logic [WIDTH-1:0]   r_res;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_borrow;
   logic [WIDTH-1:0]   r_diff;
   logic               r_borrow_out;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   logic               w_last;
   logic               w_d;
   logic               w_bout;
   logic [WIDTH-1:0]   w_res_next;
   logic               w_ready_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;

   // Start is honoured only in the states where ready is advertised.
   assign w_accept   = start && (r_state != ST_RUN);
   assign w_last     = (r_state == ST_RUN) && (r_cnt == CNT_LAST);
   // The new difference bit enters from the top, so after WIDTH shifts the
   // LSB computed first sits at bit 0.
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};

   full_subtractor u_cell (
      .a    (r_sa[0]),
      .b    (r_sb[0]),
      .bin  (r_borrow),
      .diff (w_d),
      .bout (w_bout)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next_state = ST_RUN;
            else       w_next_state = ST_IDLE;
         end
         ST_RUN: begin
            if (r_cnt == CNT_LAST) w_next_state = ST_DONE;
            else                   w_next_state = ST_RUN;
         end
         ST_DONE: begin
            if (start) w_next_state = ST_RUN;
            else       w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // FSM output decode; evaluated on the next state so the flags are registered.
   always_comb begin
      w_ready_nxt = 1'b1;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (w_next_state)
         ST_IDLE: begin
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
         end
         ST_RUN: begin
            w_ready_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
         end
         ST_DONE: begin
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
         end
         default: begin
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
         end
      endcase
   end

   // Status flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Operand capture, serial shifting and result publication.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sa         <= '0;
         r_sb         <= '0;
         r_res        <= '0;
         r_cnt        <= '0;
         r_borrow     <= 1'b0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
      end else if (w_accept) begin
         r_sa     <= a;
         r_sb     <= b;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (r_state == ST_RUN) begin
         r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
         r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
         r_res    <= w_res_next;
         r_borrow <= w_bout;
         r_cnt    <= r_cnt + CNT_W'(1);
         // diff is a separate register so it stays stable during RUN.
         if (w_last) begin
            r_diff       <= w_res_next;
            r_borrow_out <= w_bout;
         end
      end
   end

   assign ready      = r_ready;
   assign busy       = r_busy;
   assign done       = r_done;
   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;

endmodule
